// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage controller.
// Holds the fetch FSM state type, the bubble instruction and the PC step.
package fetch_pkg;

    // ISSUE: request in flight this cycle; WAIT: awaiting response;
    // HOLD: response parked in the skid buffer; DRAIN: discard a stale response.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam int          PC_INC      = 2;
    localparam int          INSTR_W_DEF = 16;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer that parks an instruction returned by
// memory while the decode stage is stalled. Clear wins over load.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int W = INSTR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Capture the parked instruction and track whether it is still live.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // NOTE: the data word is reset as well; it is a single entry, so a known value costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the 16-bit pipelined core.
// Owns PCF, keeps at most one instruction-memory request outstanding and
// loads the F/D register. Execute redirects (PCSrcE) beat everything else.
// Optional: define FETCH_CTRL_PERF_EN to add PerfFetchCnt/PerfStallCnt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallF,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [PC_W-1:0]    PCTargetE,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic [PC_W-1:0]    PCPlus2D,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]        PerfFetchCnt,
    output logic [31:0]        PerfStallCnt,
`endif
    output logic               ValidD
);

    fetch_state_t       state_q;
    logic [PC_W-1:0]    pcf_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pcd_q;
    logic [PC_W-1:0]    pcp2_q;
    logic               valid_q;

    logic [PC_W-1:0]    pc_tgt;
    logic [PC_W-1:0]    pc_inc;
    logic               rsp_take;
    logic               buf_take;
    logic               fd_load;
    logic               fd_kill;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_data;
    logic [INSTR_W-1:0] fd_instr;

    // Decode which edge actions this cycle performs from state and hazard inputs.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        rsp_take   = 1'b0;
        buf_take   = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        pc_tgt     = PCTargetE & ~PC_W'(1);
        pc_inc     = pcf_q + PC_W'(PC_INC);
        unique case (state_q)
            WAIT: begin
                rsp_take  = imem_rvalid && !PCSrcE && !StallF;
                skid_load = imem_rvalid && !PCSrcE && StallF;
            end
            HOLD: begin
                buf_take   = skid_valid && !PCSrcE && !StallF;
                skid_clear = PCSrcE || !StallF;
            end
            default: ;
        endcase
        fd_load  = rsp_take || buf_take;
        fd_kill  = FlushD || PCSrcE;
        fd_instr = buf_take ? skid_data : imem_rdata;
    end

    fetch_skid_buf #(
        .W(INSTR_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .data_i (imem_rdata),
        .data_o (skid_data),
        .valid_o(skid_valid)
    );

    // Fetch FSM: sequences requests and owns PCF; a redirect always retargets PCF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ISSUE;
            pcf_q   <= RESET_PC;
        end else begin
            unique case (state_q)
                ISSUE: begin
                    state_q <= WAIT;
                    if (PCSrcE) begin
                        pcf_q   <= pc_tgt;
                        state_q <= DRAIN;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= ISSUE;
                        if (PCSrcE) begin
                            pcf_q <= pc_tgt;
                        end else if (!StallF) begin
                            pcf_q <= pc_inc;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (PCSrcE) begin
                        pcf_q   <= pc_tgt;
                        state_q <= DRAIN;
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        pcf_q   <= pc_tgt;
                        state_q <= ISSUE;
                    end else if (!StallF) begin
                        pcf_q   <= pc_inc;
                        state_q <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (PCSrcE) begin
                        pcf_q <= pc_tgt;
                    end
                    if (imem_rvalid) begin
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    // F/D register: kill beats stall, stall beats load, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= INSTR_W'(NOP_INSTR);
            pcd_q   <= '0;
            pcp2_q  <= '0;
            valid_q <= 1'b0;
        end else if (fd_kill) begin
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (!StallF) begin
            if (fd_load) begin
                instr_q <= fd_instr;
                pcd_q   <= pcf_q;
                pcp2_q  <= pc_inc;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Count real instructions entering decode and cycles the hazard unit stalls fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fd_load && !fd_kill) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (StallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign PerfFetchCnt = fetch_cnt_q;
    assign PerfStallCnt = stall_cnt_q;
`else
    // Default build carries no performance counters.
`endif

    // Requests are suppressed while reset is held even though the state reads ISSUE.
    assign imem_req  = rst && (state_q == ISSUE);
    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus2D  = pcp2_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed steps followed by randomized traffic for two fetch_ctrl
// instances (RESET_PC 0000 and FFFE), each with its own variable-latency memory.
// Expected values come from a transaction-level model of the fetch stage.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall  [2];
    logic        flush  [2];
    logic        redir  [2];
    logic [15:0] tgt    [2];
    logic        rvalid [2];
    logic [15:0] rdata  [2];
    logic        req    [2];
    logic [15:0] addr   [2];
    logic [15:0] pcf    [2];
    logic [15:0] instr  [2];
    logic [15:0] pcd    [2];
    logic [15:0] pcp2   [2];
    logic        vld    [2];
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fcnt   [2];
    logic [31:0] scnt   [2];
`endif

    fetch_ctrl #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .StallF(stall[0]), .FlushD(flush[0]), .PCSrcE(redir[0]),
        .PCTargetE(tgt[0]), .imem_req(req[0]), .imem_addr(addr[0]), .imem_rvalid(rvalid[0]),
        .imem_rdata(rdata[0]), .PCF(pcf[0]), .InstrD(instr[0]), .PCD(pcd[0]),
        .PCPlus2D(pcp2[0]),
`ifdef FETCH_CTRL_PERF_EN
        .PerfFetchCnt(fcnt[0]), .PerfStallCnt(scnt[0]),
`endif
        .ValidD(vld[0])
    );

    fetch_ctrl #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) u_dut_hi (
        .clk(clk), .rst(rst), .StallF(stall[1]), .FlushD(flush[1]), .PCSrcE(redir[1]),
        .PCTargetE(tgt[1]), .imem_req(req[1]), .imem_addr(addr[1]), .imem_rvalid(rvalid[1]),
        .imem_rdata(rdata[1]), .PCF(pcf[1]), .InstrD(instr[1]), .PCD(pcd[1]),
        .PCPlus2D(pcp2[1]),
`ifdef FETCH_CTRL_PERF_EN
        .PerfFetchCnt(fcnt[1]), .PerfStallCnt(scnt[1]),
`endif
        .ValidD(vld[1])
    );

    // Model view: a PC, whether a request is outstanding (and unwanted), an optional
    // parked instruction, and the F/D contents.
    typedef struct packed {
        logic [15:0] pc;
        logic        busy;
        logic        disc;
        logic        skid_v;
        logic [15:0] skid_d;
        logic [15:0] instr;
        logic [15:0] pcd;
        logic [15:0] pcp2;
        logic        vld;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } mdl_t;

    typedef struct packed {
        logic        pend;
        logic [15:0] a;
        logic [2:0]  cnt;
    } mem_t;

    mdl_t        mdl     [2];
    mem_t        mem     [2];
    int          mem_lat [2];
    logic        smp_req [2];
    logic [15:0] smp_addr[2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [15:0] rst_pc(input int i);
        return (i == 0) ? 16'h0000 : 16'hFFFE;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic st, input logic fl, input logic rd,
                                   input logic [15:0] tg, input logic rv, input logic [15:0] rdat);
        mdl_t        n;
        logic        load;
        logic [15:0] ld_i;
        logic [15:0] ld_pc;
        logic [15:0] t;
        n     = m;
        load  = 1'b0;
        ld_i  = '0;
        ld_pc = '0;
        t     = {tg[15:1], 1'b0};
        if (m.skid_v) begin
            if (rd) begin
                n.skid_v = 1'b0;
                n.pc     = t;
            end else if (!st) begin
                load     = 1'b1;
                ld_i     = m.skid_d;
                ld_pc    = m.pc;
                n.skid_v = 1'b0;
                n.pc     = m.pc + 16'd2;
            end
        end else if (!m.busy) begin
            n.busy = 1'b1;
            n.disc = rd;
            if (rd) n.pc = t;
        end else if (m.disc) begin
            if (rd) n.pc = t;
            if (rv) begin
                n.busy = 1'b0;
                n.disc = 1'b0;
            end
        end else if (rv) begin
            n.busy = 1'b0;
            if (rd) begin
                n.pc = t;
            end else if (!st) begin
                load  = 1'b1;
                ld_i  = rdat;
                ld_pc = m.pc;
                n.pc  = m.pc + 16'd2;
            end else begin
                n.skid_v = 1'b1;
                n.skid_d = rdat;
            end
        end else if (rd) begin
            n.pc   = t;
            n.disc = 1'b1;
        end
        if (fl || rd) begin
            n.vld   = 1'b0;
            n.instr = 16'h0000;
        end else if (!st) begin
            if (load) begin
                n.instr = ld_i;
                n.pcd   = ld_pc;
                n.pcp2  = ld_pc + 16'd2;
                n.vld   = 1'b1;
                n.fcnt  = m.fcnt + 32'd1;
            end else begin
                n.vld = 1'b0;
            end
        end
        if (st) n.scnt = m.scnt + 32'd1;
        return n;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check1 ($sformatf("imem_req[%0d]", i), req[i], !mdl[i].busy && !mdl[i].skid_v);
            check16($sformatf("imem_addr[%0d]", i), addr[i], mdl[i].pc);
            check16($sformatf("PCF[%0d]", i), pcf[i], mdl[i].pc);
            check1 ($sformatf("ValidD[%0d]", i), vld[i], mdl[i].vld);
            check16($sformatf("InstrD[%0d]", i), instr[i], mdl[i].instr);
            check16($sformatf("PCD[%0d]", i), pcd[i], mdl[i].pcd);
            check16($sformatf("PCPlus2D[%0d]", i), pcp2[i], mdl[i].pcp2);
`ifdef FETCH_CTRL_PERF_EN
            check32($sformatf("PerfFetchCnt[%0d]", i), fcnt[i], mdl[i].fcnt);
            check32($sformatf("PerfStallCnt[%0d]", i), scnt[i], mdl[i].scnt);
`endif
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cyc();
        for (int i = 0; i < 2; i++) begin
            rvalid[i] = mem[i].pend && (mem[i].cnt == 3'd0);
            rdata[i]  = rvalid[i] ? (mem[i].a ^ 16'hA000) : 16'($urandom);
        end
        #1;
        compare_all();
        for (int i = 0; i < 2; i++) begin
            smp_req[i]  = req[i];
            smp_addr[i] = addr[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            mdl[i] = mstep(mdl[i], stall[i], flush[i], redir[i], tgt[i], rvalid[i], rdata[i]);
            if (rvalid[i]) mem[i].pend = 1'b0;
            else if (mem[i].pend) mem[i].cnt = mem[i].cnt - 3'd1;
            if (smp_req[i]) begin
                mem[i].pend = 1'b1;
                mem[i].a    = smp_addr[i];
                mem[i].cnt  = 3'((mem_lat[i] == 0) ? $urandom_range(1, 4) - 1 : mem_lat[i] - 1);
            end
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle (no clock edge), check async values, release.
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid[i] = 1'b0;
            stall[i]  = 1'b0;
            flush[i]  = 1'b0;
            redir[i]  = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check1 ($sformatf("rst_req[%0d]", i), req[i], 1'b0);
            check16($sformatf("rst_PCF[%0d]", i), pcf[i], rst_pc(i));
            check1 ($sformatf("rst_ValidD[%0d]", i), vld[i], 1'b0);
            check16($sformatf("rst_InstrD[%0d]", i), instr[i], 16'h0000);
            check16($sformatf("rst_PCD[%0d]", i), pcd[i], 16'h0000);
            check16($sformatf("rst_PCPlus2D[%0d]", i), pcp2[i], 16'h0000);
            mdl[i]    = '0;
            mdl[i].pc = rst_pc(i);
            mem[i]    = '0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check1 ($sformatf("first_req[%0d]", i), req[i], 1'b1);
            check16($sformatf("first_addr[%0d]", i), addr[i], rst_pc(i));
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stall[i] = 1'b0; flush[i] = 1'b0; redir[i] = 1'b0;
            tgt[i] = 16'h0000; rvalid[i] = 1'b0; rdata[i] = 16'h0000;
            mem_lat[i] = 1; mdl[i] = '0; mem[i] = '0;
        end
        @(negedge clk);
        do_reset();

        // Stream with 1-cycle memory: one instruction every two cycles.
        cyc(); cyc();
        check16("s_instr0", instr[0], 16'hA000);
        check16("s_pcp2_0", pcp2[0], 16'h0002);
        check1 ("s_valid0", vld[0], 1'b1);
        cyc();
        check1 ("s_bubble", vld[0], 1'b0);
        cyc();
        check16("s_instr1", instr[0], 16'hA002);
        check16("s_pcp2_1", pcp2[0], 16'h0004);
        cyc(); cyc();
        check16("s_instr2", instr[0], 16'hA004);
        check16("s_pcp2_2", pcp2[0], 16'h0006);

        // Reset asserted while a slow response is pending.
        mem_lat[0] = 3;
        cyc();
        do_reset();

        // Redirect during WAIT: late response dropped, refetch at aligned target.
        cyc();
        redir[0] = 1'b1; tgt[0] = 16'h0011;
        cyc();
        redir[0] = 1'b0;
        check16("r_pcf", pcf[0], 16'h0010);
        check16("w_pcd_hi", pcd[1], 16'hFFFE);
        check16("w_pcp2_hi", pcp2[1], 16'h0000);
        check16("w_instr_hi", instr[1], 16'h5FFE);
        check16("w_addr_hi", addr[1], 16'h0000);
        cyc();
        flush[1] = 1'b1;
        cyc();
        flush[1] = 1'b0;
        check1 ("r_req", req[0], 1'b1);
        check16("r_addr", addr[0], 16'h0010);
        check1 ("r_valid", vld[0], 1'b0);
        check1 ("f_valid_hi", vld[1], 1'b0);
        check16("f_instr_hi", instr[1], 16'h0000);
        mem_lat[0] = 1;
        cyc(); cyc();
        check16("r_instr", instr[0], 16'hA010);
        check16("r_pcd", pcd[0], 16'h0010);

        // Stall across response arrival: parked, D held, then released.
        stall[0] = 1'b1;
        cyc(); cyc(); cyc();
        check16("h_instr", instr[0], 16'hA010);
        check16("h_pcf", pcf[0], 16'h0012);
        check1 ("h_req", req[0], 1'b0);
        stall[0] = 1'b0;
        cyc();
        check16("h_instr_rel", instr[0], 16'hA012);
        check16("h_pcd_rel", pcd[0], 16'h0012);
        check16("h_pcf_rel", pcf[0], 16'h0014);

`ifdef FETCH_CTRL_PERF_EN
        // Four fetches then three stall cycles.
        do_reset();
        repeat (8) cyc();
        stall[0] = 1'b1;
        repeat (3) cyc();
        stall[0] = 1'b0;
        check32("p_fetch", fcnt[0], 32'd4);
        check32("p_stall", scnt[0], 32'd3);
`endif

        // Randomized traffic with variable latency and occasional resets.
        mem_lat[0] = 0;
        mem_lat[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            for (int i = 0; i < 2; i++) begin
                stall[i] = ($urandom_range(0, 3) == 0);
                flush[i] = ($urandom_range(0, 7) == 0);
                redir[i] = ($urandom_range(0, 9) == 0);
                tgt[i]   = ($urandom_range(0, 3) == 0) ? (16'hFFFE | 16'($urandom_range(0, 1)))
                                                        : 16'($urandom);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
